// File: rtl/five_ch_debounce.sv
// five_ch_debounce
//   Five-channel input conditioner for the three-out-of-five vote logic.
//   Each raw asynchronous input passes through a 2-flop synchroniser. It then goes
//   through a per-channel debounce counter. The result is a clean 5-bit bus
//   (bit0 = in_1 ... bit4 = in_5).
//   A new level is accepted once the synchronised input has disagreed with the
//   accepted level for DB_CYCLES consecutive cycles. Any bounce back to the accepted
//   level restarts the count from zero.
//   change pulses for one cycle whenever clean_out takes a new value. stable is high
//   while every channel is quiescent.
//   Optional feature, macro THREE_OF_FIVE_VOTE_EN: a registered exactly-3-of-5 vote
//   of clean_out on vote_out. Without the macro, vote_out is tied to 0.
module five_ch_debounce #(
    parameter int DB_CYCLES = 8,  // consecutive mismatch cycles to accept a level (>= 1)
    parameter int CNT_W     = 4   // counter width, must hold DB_CYCLES-1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] raw_in,
    output logic [4:0] clean_out,
    output logic       change,
    output logic       stable,
    output logic       vote_out
);

    localparam int               N_CH     = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_CH-1:0]  sync_1;
    logic [N_CH-1:0]  sync_2;
    logic [N_CH-1:0]  mismatch;
    logic [N_CH-1:0]  clean_nxt;
    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cnt_nxt [N_CH];

    // A channel is in mismatch while its synchronised level disagrees with the accepted one.
    assign mismatch = sync_2 ^ clean_out;

    // Two-flop synchroniser for the asynchronous raw inputs.
    // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= raw_in;
            sync_2 <= sync_1;
        end
    end

    // Debounce next-state: count mismatch cycles, accept the new level on the last one.
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        clean_nxt = clean_out;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i] = '0;
            if (mismatch[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    clean_nxt[i] = sync_2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state: counters, the accepted levels and the change pulse.
    // NOTE: the counter array is reset explicitly. stable reads it, and a reset mid-count
    // must discard any partial count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
            clean_out <= '0;
            change    <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            clean_out <= clean_nxt;
            change    <= (clean_nxt != clean_out);
        end
    end

    // Quiescence: no channel in mismatch and no channel with a count in progress.
    always_comb begin
        stable = (mismatch == '0);
        for (int i = 0; i < N_CH; i++) begin
            if (cnt[i] != '0) begin
                stable = 1'b0;
            end
        end
    end

`ifdef THREE_OF_FIVE_VOTE_EN
    // Registered exactly-three-of-five vote over the clean bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_out <= 1'b0;
        end else begin
            vote_out <= ($countones(clean_out) == 3);
        end
    end
`else
    assign vote_out = 1'b0;
`endif

endmodule

// File: tb/tb_five_ch_debounce.sv
// tb_five_ch_debounce
//   Drives two instances from the same raw inputs: DB_CYCLES=4 (a) and DB_CYCLES=1 (b).
//   Each instance is compared against a history-window reference model. That model
//   keeps the raw values sampled at every edge. A channel accepts a new level when its
//   last DB_CYCLES synchronised samples all disagree with the accepted level. The
//   channel is quiescent when its last two synchronised samples agree with it.
module tb_five_ch_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] raw_in = '0;

    logic [4:0] clean_a, clean_b;
    logic       change_a, change_b, stable_a, stable_b, vote_a, vote_b;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference-model state, one slot per instance. hist[d][0] is the newest raw sample.
    int         db [2] = '{4, 1};
    logic [4:0] hist [2][16];
    logic [4:0] m_clean [2];
    logic       m_change [2];
    logic       m_stable [2];
    logic       m_vote [2];

    always #5 clk = ~clk;

    five_ch_debounce #(.DB_CYCLES(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .raw_in(raw_in),
        .clean_out(clean_a), .change(change_a), .stable(stable_a), .vote_out(vote_a)
    );

    five_ch_debounce #(.DB_CYCLES(1), .CNT_W(1)) dut_b (
        .clk(clk), .rst(rst), .raw_in(raw_in),
        .clean_out(clean_b), .change(change_b), .stable(stable_b), .vote_out(vote_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 16; j++) hist[d][j] = '0;
            m_clean[d]  = '0;
            m_change[d] = 1'b0;
            m_stable[d] = 1'b1;
            m_vote[d]   = 1'b0;
        end
    endtask

    // One rising edge of the reference model with raw value 'raw' present at that edge.
    task automatic model_edge(input logic [4:0] raw);
        for (int d = 0; d < 2; d++) begin
            logic [4:0] all_differ;
            logic [4:0] new_clean;
            all_differ = '1;
            // Pre-edge synchronised samples over the last db edges are hist[1..db].
            for (int j = 1; j <= db[d]; j++) all_differ &= hist[d][j] ^ m_clean[d];
            new_clean = m_clean[d] ^ all_differ;
`ifdef THREE_OF_FIVE_VOTE_EN
            m_vote[d] = ($countones(m_clean[d]) == 3);
`else
            m_vote[d] = 1'b0;
`endif
            m_change[d] = (new_clean != m_clean[d]);
            for (int j = 15; j > 0; j--) hist[d][j] = hist[d][j-1];
            hist[d][0] = raw;
            m_clean[d] = new_clean;
            m_stable[d] = (((hist[d][1] ^ new_clean) | (hist[d][2] ^ new_clean)) == '0);
        end
    endtask

    task automatic check_all();
        check("a.clean",  32'(clean_a),  32'(m_clean[0]));
        check("a.change", 32'(change_a), 32'(m_change[0]));
        check("a.stable", 32'(stable_a), 32'(m_stable[0]));
        check("a.vote",   32'(vote_a),   32'(m_vote[0]));
        check("b.clean",  32'(clean_b),  32'(m_clean[1]));
        check("b.change", 32'(change_b), 32'(m_change[1]));
        check("b.stable", 32'(stable_b), 32'(m_stable[1]));
        check("b.vote",   32'(vote_b),   32'(m_vote[1]));
    endtask

    // Called at a falling edge: drive raw, run one rising edge, check at the next falling edge.
    task automatic step(input logic [4:0] v);
        raw_in = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        check_all();
    endtask

    // Called at a falling edge: assert reset with raw value v, hold it, release at a falling edge.
    task automatic do_reset(input logic [4:0] v);
        raw_in = v;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #1;
        // 1. Reset with 10101 present, then accept at edge 6 after release.
        @(negedge clk);
        do_reset(5'b10101);
        check("s1.rst_clean", 32'(clean_a), 32'd0);
        check("s1.rst_stable", 32'(stable_a), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            step(5'b10101);
            if (k == 5) check("s1.clean_e5", 32'(clean_a), 32'h00);
            if (k == 6) begin
                check("s1.clean_e6", 32'(clean_a), 32'h15);
                check("s1.change_e6", 32'(change_a), 32'd1);
            end
            if (k == 7) check("s1.change_e7", 32'(change_a), 32'd0);
        end

        // 2. A short pulse on channel 0 is rejected.
        do_reset(5'b00000);
        for (int k = 0; k < 3; k++) step(5'b00001);
        for (int k = 0; k < 6; k++) step(5'b00000);
        check("s2.clean", 32'(clean_a), 32'h00);
        check("s2.stable", 32'(stable_a), 32'd1);

        // 3. 00111 held, then the vote a cycle later.
        for (int k = 1; k <= 8; k++) begin
            step(5'b00111);
            if (k == 6) check("s3.clean_e6", 32'(clean_a), 32'h07);
`ifdef THREE_OF_FIVE_VOTE_EN
            if (k == 7) check("s3.vote_e7", 32'(vote_a), 32'd1);
`else
            if (k == 7) check("s3.vote_e7", 32'(vote_a), 32'd0);
`endif
        end

        // 4. Fourth channel active: the vote drops.
        for (int k = 1; k <= 8; k++) step(5'b01111);
        check("s4.clean", 32'(clean_a), 32'h0F);
        check("s4.vote", 32'(vote_a), 32'd0);

        // 5. Reset mid-count on channel 0, then the full latency again.
        do_reset(5'b00000);
        for (int k = 0; k < 4; k++) step(5'b00001);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(5'b00001);
            if (k == 5) check("s5.clean_e5", 32'(clean_a), 32'h00);
            if (k == 6) check("s5.clean_e6", 32'(clean_a), 32'h01);
        end

        // 6. DB_CYCLES=1 instance: accepted at edge 3.
        do_reset(5'b00000);
        for (int k = 1; k <= 3; k++) begin
            step(5'b10000);
            if (k == 2) check("s6.clean_e2", 32'(clean_b), 32'h00);
            if (k == 3) check("s6.clean_e3", 32'(clean_b), 32'h10);
        end

        // Randomized segments: a held target with random bounce, plus occasional resets.
        for (int s = 0; s < 80; s++) begin
            logic [4:0] target;
            int         hold;
            target = 5'($urandom);
            hold   = $urandom_range(1, 12);
            if ($urandom_range(0, 24) == 0) do_reset(5'($urandom));
            for (int k = 0; k < hold; k++) begin
                logic [4:0] v;
                v = target;
                if ($urandom_range(0, 3) == 0) v ^= 5'($urandom);
                step(v);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
